// File: rtl/bin2bcd_4digit.sv
// -----------------------------------------------------------------------------
// bin2bcd_4digit
//
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that feeds
// a 4-digit seven-segment driver. It converts an unsigned binary value in the
// range 0..9999 into four BCD digits, d3 (thousands) down to d0 (units). Any
// value above 9999 is flagged as overflow, and all four digits then show 4'hF.
//
// The digit and overflow outputs change together, only when a conversion
// completes. The display therefore never shows a partially converted value.
//
// Timing, with the start edge called E0:
//   E0                 : bin_in captured, busy rises
//   E0+1 .. E0+BIN_W   : one shift-add-3 iteration per clock
//   E0+BIN_W           : busy falls, FSM enters DONE
//   E0+BIN_W+1         : digits/ovf updated, done pulses for one cycle
// If start is held high, a new value is accepted every BIN_W+2 clocks.
//
// Parameters
//   BIN_W   width of bin_in (legal 4..16)
//
// Ports
//   clk     in   1      system clock, all state on rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      conversion request, accepted only in IDLE
//   bin_in  in   BIN_W  unsigned value, sampled when start is accepted
//   busy    out  1      high while the shift iterations are running
//   done    out  1      one-cycle pulse: digits/ovf just updated
//   ovf     out  1      last completed value was > 9999
//   d0..d3  out  4      BCD digits (units .. thousands), 4'hF on overflow
// -----------------------------------------------------------------------------
module bin2bcd_4digit #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    // The counter must be able to hold BIN_W itself (up to 16).
    localparam int          CNT_W   = 5;
    localparam logic [16:0] MAX_VAL = 17'd9999;

    state_e             state_q,    state_d;
    logic [BIN_W-1:0]   shift_q,    shift_d;
    logic [15:0]        scratch_q,  scratch_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               ovf_q,      ovf_d;
    logic [15:0]        digits_q,   digits_d;

    logic [15:0]        scratch_adj;

    // Each BCD nibble of 5 or more gets +3 before the shift. The nibble that
    // comes out of the shift then carries correctly into the next decade.
    // The add wraps within 4 bits. This only matters for values above 9999,
    // and overflow overrides the digits for those anyway.
    function automatic logic [15:0] add3(input logic [15:0] s);
        logic [15:0] r;
        logic [3:0]  nib;
        r = s;
        for (int i = 0; i < 4; i++) begin
            nib = s[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            r[4*i +: 4] = nib;
        end
        return r;
    endfunction

    assign scratch_adj = add3(scratch_q);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        digits_d   = digits_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d    = bin_in;
                    scratch_d  = 16'h0000;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = (17'(bin_in) > MAX_VAL);
                    busy_d     = 1'b1;
                    state_d    = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // Shift {scratch, shift} left by one. The binary MSB enters
                // scratch bit 0, and the top adjusted scratch bit is dropped.
                scratch_d = {scratch_adj[14:0], shift_q[BIN_W-1]};
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // All visible outputs update in this single edge.
                digits_d = ovf_pend_q ? 16'hFFFF : scratch_q;
                ovf_d    = ovf_pend_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every register
    // samples its pre-edge value, whatever order the statements appear in.
    // NOTE: the datapath registers (shift, scratch, counter) are reset along
    // with the control. A reset in mid-conversion then leaves nothing stale
    // behind, and no output can be X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            scratch_q  <= 16'h0000;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            digits_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign d3   = digits_q[15:12];
    assign d2   = digits_q[11:8];
    assign d1   = digits_q[7:4];
    assign d0   = digits_q[3:0];

endmodule

// File: tb/tb_bin2bcd_4digit.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_4digit
//
// Directed bench for bin2bcd_4digit (BIN_W = 14, 100 MHz clock).
// Table-driven conversions are followed by hand-written sequences:
// a start request during a conversion, start held high, and a reset in
// mid-conversion. Inputs change one time unit after the rising edge.
// Outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_bin2bcd_4digit;

    localparam int BIN_W   = 14;
    localparam int LAT     = BIN_W + 1;
    localparam int BUSY_N  = BIN_W;
    localparam int PERIOD  = BIN_W + 2;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       d0, d1, d2, d3;

    bin2bcd_4digit #(.BIN_W(BIN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .d0     (d0),
        .d1     (d1),
        .d2     (d2),
        .d3     (d3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Digit values expected to be visible until the next completion.
    logic [15:0] prev_digits = 16'h0000;
    logic        prev_ovf    = 1'b0;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic [15:0]      digits;   // {d3,d2,d1,d0}
        logic             ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] digits_now();
        return {d3, d2, d1, d0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One conversion with a single-cycle start. This checks the latency, the
    // busy length, the atomic update of the digits, and the one-cycle done.
    task automatic convert(input string name, input logic [BIN_W-1:0] v,
                           input logic [15:0] exp_d, input logic exp_ovf);
        int  busy_cnt;
        int  lat;
        bit  got;
        bit  atomic_ok;
        busy_cnt  = 0;
        lat       = -1;
        got       = 1'b0;
        atomic_ok = 1'b1;
        start  = 1'b1;
        bin_in = v;
        step();                     // E0 accepted; now E0+1ns
        start  = 1'b0;
        bin_in = BIN_W'($urandom);  // must not affect the running conversion
        for (int k = 0; k < TIMEOUT; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                got = 1'b1;
                break;
            end
            if (digits_now() !== prev_digits || ovf !== prev_ovf) atomic_ok = 1'b0;
            step();
        end
        check({name, " done seen"}, 32'(got), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(LAT));
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(BUSY_N));
        check({name, " digits held"}, 32'(atomic_ok), 32'd1);
        check({name, " digits"}, 32'(digits_now()), 32'(exp_d));
        check({name, " ovf"}, 32'(ovf), 32'(exp_ovf));
        step();
        check({name, " done one cycle"}, 32'(done), 32'd0);
        prev_digits = exp_d;
        prev_ovf    = exp_ovf;
    endtask

    vec_t vecs[9];

    initial begin
        int accepts;
        int dones;
        int done_t[3];
        logic [15:0] done_d[3];
        bit busy_prev;
        bit extra;

        vecs[0] = '{bin: 14'd1234,  digits: 16'h1234, ovf: 1'b0};
        vecs[1] = '{bin: 14'd0,     digits: 16'h0000, ovf: 1'b0};
        vecs[2] = '{bin: 14'd9999,  digits: 16'h9999, ovf: 1'b0};
        vecs[3] = '{bin: 14'd5,     digits: 16'h0005, ovf: 1'b0};
        vecs[4] = '{bin: 14'd10000, digits: 16'hFFFF, ovf: 1'b1};
        vecs[5] = '{bin: 14'd16383, digits: 16'hFFFF, ovf: 1'b1};
        vecs[6] = '{bin: 14'd42,    digits: 16'h0042, ovf: 1'b0};
        vecs[7] = '{bin: 14'd809,   digits: 16'h0809, ovf: 1'b0};
        vecs[8] = '{bin: 14'd1000,  digits: 16'h1000, ovf: 1'b0};

        // ---------------- reset ----------------
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset digits", 32'(digits_now()), 32'h0000);
        rst_n = 1'b1;
        step();

        // ---------------- table ----------------
        for (int i = 0; i < 9; i++) begin
            convert($sformatf("vec%0d(%0d)", i, vecs[i].bin), vecs[i].bin,
                    vecs[i].digits, vecs[i].ovf);
            step();
        end

        // ---------------- start ignored while converting ----------------
        start  = 1'b1;
        bin_in = 14'd42;
        step();                         // E0
        start  = 1'b0;
        repeat (4) step();              // now E0+4+1ns
        start  = 1'b1;
        bin_in = 14'd7;                 // sampled at E0+5, must be ignored
        step();
        start  = 1'b0;
        dones  = 0;
        done_t[0] = -1;
        for (int k = 5; k < 5 + 40; k++) begin
            if (done) begin
                if (dones == 0) begin
                    done_t[0] = k;
                    done_d[0] = digits_now();
                end
                dones++;
            end
            step();
        end
        check("restart done time", 32'(done_t[0]), 32'(LAT));
        check("restart digits", 32'(done_d[0]), 32'h0042);
        check("restart single done", 32'(dones), 32'd1);
        check("restart idle busy", 32'(busy), 32'd0);

        // ---------------- start held high ----------------
        start     = 1'b1;
        bin_in    = 14'd1;
        accepts   = 0;
        dones     = 0;
        busy_prev = 1'b0;
        for (int k = 0; k < 80 && dones < 3; k++) begin
            step();
            if (busy && !busy_prev) begin
                accepts++;
                bin_in = BIN_W'(accepts + 1);
            end
            busy_prev = busy;
            if (done) begin
                done_t[dones] = k;
                done_d[dones] = digits_now();
                dones++;
                if (dones == 3) start = 1'b0;
            end
        end
        check("held done count", 32'(dones), 32'd3);
        if (dones == 3) begin
            check("held spacing 1-2", 32'(done_t[1] - done_t[0]), 32'(PERIOD));
            check("held spacing 2-3", 32'(done_t[2] - done_t[1]), 32'(PERIOD));
            check("held digits 1", 32'(done_d[0]), 32'h0001);
            check("held digits 2", 32'(done_d[1]), 32'h0002);
            check("held digits 3", 32'(done_d[2]), 32'h0003);
        end
        repeat (3) step();
        check("held no 4th busy", 32'(busy), 32'd0);
        prev_digits = 16'h0003;
        prev_ovf    = 1'b0;

        // ---------------- async reset mid-conversion ----------------
        start  = 1'b1;
        bin_in = 14'd1234;
        step();                         // E0
        start  = 1'b0;
        repeat (6) step();              // E0+6+1ns
        @(posedge clk);                 // E0+7
        #2;
        rst_n = 1'b0;
        #1;                             // still before the next edge
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst digits", 32'(digits_now()), 32'h0000);
        check("async rst ovf", 32'(ovf), 32'd0);
        step();
        rst_n = 1'b1;
        extra = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (done || busy) extra = 1'b1;
            step();
        end
        check("no done after reset", 32'(extra), 32'd0);
        prev_digits = 16'h0000;
        prev_ovf    = 1'b0;
        convert("post-reset 1234", 14'd1234, 16'h1234, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
